// File: rtl/turn_buffer.sv
// turn_buffer: holds a blocked turn request for a bounded number of frames
// and emits it once the wall logic reports that direction as open.
// Optional feature macro: TURN_BUFFER_REVERSE_EN (a reversal of cur_dir is
// always legal, regardless of can_turn).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no request held; legal requests are emitted immediately
// PENDING  | a blocked request is held; timer counts frames until it drops
// FROZEN   | isDefeated high; requests ignored, outputs held, nothing held
module turn_buffer #(
  parameter int TIMEOUT = 16
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic [7:0] keycode_in,
  input  logic [3:0] can_turn,
  input  logic       isDefeated,
  output logic [7:0] keycode_out,
  output logic [1:0] cur_dir,
  output logic       pending_valid,
  output logic [1:0] pending_dir
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_FROZEN  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    A_HOLD      = 3'd0,
    A_EMIT_REQ  = 3'd1,
    A_EMIT_PEND = 3'd2,
    A_LOAD      = 3'd3,
    A_DEC       = 3'd4,
    A_CLEAR     = 3'd5
  } action_t;

  localparam logic [5:0] TIMEOUT_LD = 6'(TIMEOUT);

  state_t     state, state_nxt;
  action_t    act;
  logic [5:0] cnt, cnt_nxt;
  logic [7:0] keycode_nxt;
  logic [1:0] cur_dir_nxt;
  logic       pending_valid_nxt;
  logic [1:0] pending_dir_nxt;

  logic       req_valid;
  logic [1:0] req_dir;
  logic       has_emitted;
  logic       req_same;
  logic       req_legal;
  logic       pend_legal;

  function automatic logic [7:0] dir_code(input logic [1:0] d);
    case (d)
      2'd0:    dir_code = 8'h07;
      2'd1:    dir_code = 8'h16;
      2'd2:    dir_code = 8'h04;
      default: dir_code = 8'h1A;
    endcase
  endfunction

  // Keycode decode: only the four direction keys form a request.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = 2'd0;
    case (keycode_in)
      8'h07:   req_dir = 2'd0;
      8'h16:   req_dir = 2'd1;
      8'h04:   req_dir = 2'd2;
      8'h1A:   req_dir = 2'd3;
      default: req_valid = 1'b0;
    endcase
  end

  // Until the first emission keycode_out is 0x00 and cur_dir carries no
  // meaning, so a "same direction" or "reversal" cannot exist yet.
  assign has_emitted = (keycode_out != 8'h00);
  assign req_same    = req_valid && has_emitted && (req_dir == cur_dir);

  // Legality of the incoming and of the held request.
  always_comb begin
`ifdef TURN_BUFFER_REVERSE_EN
    req_legal  = can_turn[req_dir] ||
                 (has_emitted && (req_dir == (cur_dir ^ 2'd2)));
    pend_legal = can_turn[pending_dir] ||
                 (has_emitted && (pending_dir == (cur_dir ^ 2'd2)));
`else
    req_legal  = can_turn[req_dir];
    pend_legal = can_turn[pending_dir];
`endif
  end

  // State and registered outputs.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= S_IDLE;
      keycode_out   <= 8'h00;
      cur_dir       <= 2'd0;
      pending_valid <= 1'b0;
      pending_dir   <= 2'd0;
      cnt           <= 6'd0;
    end else begin
      state         <= state_nxt;
      keycode_out   <= keycode_nxt;
      cur_dir       <= cur_dir_nxt;
      pending_valid <= pending_valid_nxt;
      pending_dir   <= pending_dir_nxt;
      cnt           <= cnt_nxt;
    end
  end

  // Next-state and action selection; a new request always beats the held one.
  always_comb begin
    state_nxt = state;
    act       = A_HOLD;
    if (isDefeated) begin
      state_nxt = S_FROZEN;
      act       = A_CLEAR;
    end else if (req_valid) begin
      if (req_same) begin
        state_nxt = S_IDLE;
        act       = A_CLEAR;
      end else if (req_legal) begin
        state_nxt = S_IDLE;
        act       = A_EMIT_REQ;
      end else begin
        state_nxt = S_PENDING;
        act       = A_LOAD;
      end
    end else if (state == S_PENDING) begin
      if (pend_legal) begin
        state_nxt = S_IDLE;
        act       = A_EMIT_PEND;
      end else if (cnt <= 6'd1) begin
        // Terminal count: drop instead of decrementing, so no underflow.
        state_nxt = S_IDLE;
        act       = A_CLEAR;
      end else begin
        state_nxt = S_PENDING;
        act       = A_DEC;
      end
    end else begin
      state_nxt = S_IDLE;
      act       = A_HOLD;
    end
  end

  // Next values of the registered outputs and the retry timer.
  always_comb begin
    keycode_nxt       = keycode_out;
    cur_dir_nxt       = cur_dir;
    pending_valid_nxt = pending_valid;
    pending_dir_nxt   = pending_dir;
    cnt_nxt           = cnt;
    case (act)
      A_EMIT_REQ: begin
        keycode_nxt       = dir_code(req_dir);
        cur_dir_nxt       = req_dir;
        pending_valid_nxt = 1'b0;
        pending_dir_nxt   = 2'd0;
        cnt_nxt           = 6'd0;
      end
      A_EMIT_PEND: begin
        keycode_nxt       = dir_code(pending_dir);
        cur_dir_nxt       = pending_dir;
        pending_valid_nxt = 1'b0;
        pending_dir_nxt   = 2'd0;
        cnt_nxt           = 6'd0;
      end
      A_LOAD: begin
        pending_valid_nxt = 1'b1;
        pending_dir_nxt   = req_dir;
        cnt_nxt           = TIMEOUT_LD;
      end
      A_DEC: begin
        cnt_nxt = cnt - 6'd1;
      end
      A_CLEAR: begin
        pending_valid_nxt = 1'b0;
        pending_dir_nxt   = 2'd0;
        cnt_nxt           = 6'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_turn_buffer.sv
// tb_turn_buffer: scoreboard bench for turn_buffer. Three instances share
// stimulus: default TIMEOUT, TIMEOUT=4 and TIMEOUT=1.
module tb_turn_buffer;

  logic       frame_clk;
  logic       Reset_n;
  logic [7:0] keycode_in;
  logic [3:0] can_turn;
  logic       isDefeated;

  logic [7:0] kc_a, kc_b, kc_c;
  logic [1:0] dir_a, dir_b, dir_c;
  logic       pv_a, pv_b, pv_c;
  logic [1:0] pd_a, pd_b, pd_c;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0]  kc;
    logic [3:0]  ct;
    logic        def;
    logic [25:0] exp;
  } step_t;

  logic [25:0] sb[$];

  turn_buffer dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode_in(keycode_in),
    .can_turn(can_turn), .isDefeated(isDefeated), .keycode_out(kc_a),
    .cur_dir(dir_a), .pending_valid(pv_a), .pending_dir(pd_a)
  );

  turn_buffer #(.TIMEOUT(4)) dut4 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode_in(keycode_in),
    .can_turn(can_turn), .isDefeated(isDefeated), .keycode_out(kc_b),
    .cur_dir(dir_b), .pending_valid(pv_b), .pending_dir(pd_b)
  );

  turn_buffer #(.TIMEOUT(1)) dut1 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode_in(keycode_in),
    .can_turn(can_turn), .isDefeated(isDefeated), .keycode_out(kc_c),
    .cur_dir(dir_c), .pending_valid(pv_c), .pending_dir(pd_c)
  );

  wire [12:0] obs  = {kc_a, dir_a, pv_a, pd_a};
  wire [12:0] obs4 = {kc_b, dir_b, pv_b, pd_b};
  wire [12:0] obs1 = {kc_c, dir_c, pv_c, pd_c};

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] E(input logic [7:0] kc, input logic [1:0] d,
                                    input logic pv, input logic [1:0] pd);
    E = {kc, d, pv, pd};
  endfunction

  // Apply inputs for one frame, then sample 1 time unit after the edge.
  task automatic drive(input logic [7:0] kc, input logic [3:0] ct, input logic def);
    keycode_in = kc;
    can_turn   = ct;
    isDefeated = def;
    @(posedge frame_clk);
    #1;
  endtask

  // Reset asserted mid-cycle, released on a falling edge.
  task automatic do_reset();
    Reset_n    = 1'b0;
    keycode_in = 8'h00;
    can_turn   = 4'h0;
    isDefeated = 1'b0;
    @(negedge frame_clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [25:0] e;
    do_reset();
    sb.push_back(26'd0);
    e = sb.pop_front();
    n_tests++;
    if ({obs4, obs} !== e) begin
      n_fail++;
      $display("FAIL reset_state: got %h want %h", {obs4, obs}, e);
    end
    sb.push_back({13'd0, E(8'h00, 2'd0, 1'b1, 2'd3)});
    drive(8'h1A, 4'h0, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if ({13'd0, obs} !== e) begin
      n_fail++;
      $display("FAIL reset_enter_pending: got %h want %h", obs, e[12:0]);
    end
    // Asynchronous assertion in the middle of PENDING, before any edge.
    Reset_n = 1'b0;
    sb.push_back(26'd0);
    #2;
    e = sb.pop_front();
    n_tests++;
    if ({obs4, obs} !== e) begin
      n_fail++;
      $display("FAIL reset_async_mid_pending: got %h want %h", {obs4, obs}, e);
    end
    @(negedge frame_clk);
    Reset_n = 1'b1;
    sb.push_back({13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)});
    drive(8'h07, 4'b0001, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if ({13'd0, obs} !== e) begin
      n_fail++;
      $display("FAIL reset_first_edge: got %h want %h", obs, e[12:0]);
    end
  endtask

  task automatic test_legal_emit();
    step_t s[4];
    logic [25:0] e;
    s[0] = '{8'h07, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[1] = '{8'h00, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[2] = '{8'h16, 4'b0010, 1'b0, {13'd0, E(8'h16, 2'd1, 1'b0, 2'd0)}};
    s[3] = '{8'h55, 4'b1111, 1'b0, {13'd0, E(8'h16, 2'd1, 1'b0, 2'd0)}};
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({13'd0, obs} !== e) begin
        n_fail++;
        $display("FAIL legal_emit step %0d: got %h want %h", i, obs, e[12:0]);
      end
    end
  endtask

  task automatic test_pending_retry();
    step_t s[7];
    logic [25:0] e;
    s[0] = '{8'h07, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[1] = '{8'h1A, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[2] = '{8'h00, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[3] = '{8'h00, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[4] = '{8'h00, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[5] = '{8'h00, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[6] = '{8'h00, 4'b1001, 1'b0, {13'd0, E(8'h1A, 2'd3, 1'b0, 2'd0)}};
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({13'd0, obs} !== e) begin
        n_fail++;
        $display("FAIL pending_retry step %0d: got %h want %h", i, obs, e[12:0]);
      end
    end
  endtask

  // Checked on the TIMEOUT=4 and TIMEOUT=1 instances: {obs4, obs1}.
  task automatic test_timeout();
    step_t s[10];
    logic [25:0] e;
    logic [12:0] r, p, d;
    r = E(8'h07, 2'd0, 1'b0, 2'd0);
    p = E(8'h07, 2'd0, 1'b1, 2'd1);
    s[0] = '{8'h07, 4'b0001, 1'b0, {r, r}};
    s[1] = '{8'h16, 4'b0000, 1'b0, {p, p}};
    s[2] = '{8'h00, 4'b0000, 1'b0, {p, r}};
    s[3] = '{8'h00, 4'b0000, 1'b0, {p, r}};
    s[4] = '{8'h16, 4'b0000, 1'b0, {p, p}};
    s[5] = '{8'h00, 4'b0000, 1'b0, {p, r}};
    s[6] = '{8'h00, 4'b0000, 1'b0, {p, r}};
    s[7] = '{8'h00, 4'b0000, 1'b0, {p, r}};
    s[8] = '{8'h00, 4'b0000, 1'b0, {r, r}};
    s[9] = '{8'h00, 4'b0010, 1'b0, {r, r}};
    d = 13'd0;
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({obs4, obs1} !== e) begin
        n_fail++;
        $display("FAIL timeout step %0d: got %h want %h", i, {obs4, obs1}, e);
      end
    end
    // TIMEOUT=1: one retry frame that succeeds.
    sb.push_back({d, E(8'h07, 2'd0, 1'b1, 2'd1)});
    drive(8'h16, 4'b0000, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if ({d, obs1} !== e) begin
      n_fail++;
      $display("FAIL timeout1_load: got %h want %h", obs1, e[12:0]);
    end
    sb.push_back({d, E(8'h16, 2'd1, 1'b0, 2'd0)});
    drive(8'h00, 4'b0010, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if ({d, obs1} !== e) begin
      n_fail++;
      $display("FAIL timeout1_retry: got %h want %h", obs1, e[12:0]);
    end
  endtask

  task automatic test_replace();
    step_t s[6];
    logic [25:0] e;
    s[0] = '{8'h07, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[1] = '{8'h1A, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[2] = '{8'h04, 4'b0100, 1'b0, {13'd0, E(8'h04, 2'd2, 1'b0, 2'd0)}};
    s[3] = '{8'h16, 4'b0000, 1'b0, {13'd0, E(8'h04, 2'd2, 1'b1, 2'd1)}};
    s[4] = '{8'h1A, 4'b0000, 1'b0, {13'd0, E(8'h04, 2'd2, 1'b1, 2'd3)}};
    s[5] = '{8'h00, 4'b0010, 1'b0, {13'd0, E(8'h04, 2'd2, 1'b1, 2'd3)}};
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({13'd0, obs} !== e) begin
        n_fail++;
        $display("FAIL replace step %0d: got %h want %h", i, obs, e[12:0]);
      end
    end
  endtask

  task automatic test_same_dir();
    step_t s[4];
    logic [25:0] e;
    s[0] = '{8'h07, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[1] = '{8'h1A, 4'b0000, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[2] = '{8'h07, 4'b0000, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[3] = '{8'h00, 4'b1000, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({13'd0, obs} !== e) begin
        n_fail++;
        $display("FAIL same_dir step %0d: got %h want %h", i, obs, e[12:0]);
      end
    end
  endtask

  task automatic test_freeze();
    step_t s[5];
    logic [25:0] e;
    s[0] = '{8'h07, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[1] = '{8'h1A, 4'b0000, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd3)}};
    s[2] = '{8'h16, 4'b1111, 1'b1, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[3] = '{8'h16, 4'b1111, 1'b1, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[4] = '{8'h16, 4'b1111, 1'b0, {13'd0, E(8'h16, 2'd1, 1'b0, 2'd0)}};
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({13'd0, obs} !== e) begin
        n_fail++;
        $display("FAIL freeze step %0d: got %h want %h", i, obs, e[12:0]);
      end
    end
  endtask

  task automatic test_reverse();
    step_t s[2];
    logic [25:0] e;
    s[0] = '{8'h07, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
`ifdef TURN_BUFFER_REVERSE_EN
    s[1] = '{8'h04, 4'b0001, 1'b0, {13'd0, E(8'h04, 2'd2, 1'b0, 2'd0)}};
`else
    s[1] = '{8'h04, 4'b0001, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b1, 2'd2)}};
`endif
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({13'd0, obs} !== e) begin
        n_fail++;
        $display("FAIL reverse step %0d: got %h want %h", i, obs, e[12:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[5];
    logic [25:0] e;
    s[0] = '{8'h07, 4'b1111, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    s[1] = '{8'h16, 4'b1111, 1'b0, {13'd0, E(8'h16, 2'd1, 1'b0, 2'd0)}};
    s[2] = '{8'h04, 4'b1111, 1'b0, {13'd0, E(8'h04, 2'd2, 1'b0, 2'd0)}};
    s[3] = '{8'h1A, 4'b1111, 1'b0, {13'd0, E(8'h1A, 2'd3, 1'b0, 2'd0)}};
    s[4] = '{8'h07, 4'b1111, 1'b0, {13'd0, E(8'h07, 2'd0, 1'b0, 2'd0)}};
    do_reset();
    foreach (s[i]) begin
      sb.push_back(s[i].exp);
      drive(s[i].kc, s[i].ct, s[i].def);
      e = sb.pop_front();
      n_tests++;
      if ({13'd0, obs} !== e) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h want %h", i, obs, e[12:0]);
      end
    end
  endtask

  initial begin
    Reset_n    = 1'b0;
    keycode_in = 8'h00;
    can_turn   = 4'h0;
    isDefeated = 1'b0;
    #2;
    test_reset();
    test_legal_emit();
    test_pending_retry();
    test_timeout();
    test_replace();
    test_same_dir();
    test_freeze();
    test_reverse();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
